// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load-data alignment, register
// file write port, hazard-unit taps and a retired-instruction counter.
module wb_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_valid_i,
    input  logic        mem_regwrite_i,
    input  logic        mem_memtoreg_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic [31:0] mem_alu_result_i,
    input  logic [2:0]  mem_load_type_i,
    input  logic [1:0]  mem_addr_lo_i,
    input  logic [31:0] dram_rdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        wb_valid_o,
    output logic        wb_regwrite_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] retired_o
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic        valid_p0;
    logic        regwrite_p0;
    logic        memtoreg_p0;
    logic [4:0]  waddr_p0;
    logic [31:0] alu_result_p0;
    logic [2:0]  load_type_p0;
    logic [1:0]  addr_lo_p0;
    logic        fresh_p0;
    logic [31:0] hold_p0;
    logic [31:0] retired_p0;
    logic [31:0] raw_word;

    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [2:0]  ltype,
                                               input logic [1:0]  lo);
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic [31:0]        res;
        lane_b = word[{lo, 3'b000} +: 8];
        lane_h = lo[1] ? word[31:16] : word[15:0];
        case (ltype)
            LT_LB:   res = 32'(lane_b);
            LT_LBU:  res = {24'd0, lane_b};
            LT_LH:   res = 32'(lane_h);
            LT_LHU:  res = {16'd0, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    // MEM -> WB boundary: entry register plus fresh/hold tracking of RAM data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_p0      <= 1'b0;
            regwrite_p0   <= 1'b0;
            memtoreg_p0   <= 1'b0;
            waddr_p0      <= 5'd0;
            alu_result_p0 <= 32'd0;
            load_type_p0  <= 3'd0;
            addr_lo_p0    <= 2'd0;
            fresh_p0      <= 1'b0;
            hold_p0       <= 32'd0;
        end else if (flush_i) begin
            valid_p0 <= 1'b0;
            fresh_p0 <= 1'b0;
        end else if (stall_i) begin
            fresh_p0 <= 1'b0;
            if (fresh_p0) begin
                hold_p0 <= dram_rdata_i;
            end
        end else begin
            valid_p0      <= mem_valid_i;
            regwrite_p0   <= mem_regwrite_i;
            memtoreg_p0   <= mem_memtoreg_i;
            waddr_p0      <= mem_waddr_i;
            alu_result_p0 <= mem_alu_result_i;
            load_type_p0  <= mem_load_type_i;
            addr_lo_p0    <= mem_addr_lo_i;
            fresh_p0      <= 1'b1;
        end
    end

    // An entry retires on the edge it leaves WB without being killed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_p0 <= 32'd0;
        end else if (valid_p0 && !stall_i && !flush_i) begin
            retired_p0 <= retired_p0 + 32'd1;
        end
    end

    assign raw_word      = fresh_p0 ? dram_rdata_i : hold_p0;
    assign rf_wdata_o    = memtoreg_p0 ? align_load(raw_word, load_type_p0, addr_lo_p0)
                                       : alu_result_p0;
    assign rf_we_o       = valid_p0 & regwrite_p0 & (waddr_p0 != 5'd0) & ~flush_i;
    assign rf_waddr_o    = waddr_p0;
    assign wb_waddr_o    = waddr_p0;
    assign wb_valid_o    = valid_p0;
    assign wb_regwrite_o = regwrite_p0;
    assign retired_o     = retired_p0;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage CPU kernel: MEM/WB pipeline register plus load-data alignment. It captures the instruction leaving MEM, aligns the synchronous data-RAM read data for byte/halfword/word loads, and drives the register file write port (`we`/`waddr`/`wdata`). It also exports WB-stage destination info to the hazard/forwarding unit and keeps a retired-instruction counter.

## Interface
- No parameters. Widths are fixed at 32-bit data and 5-bit register address.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `stall_i` in 1: hold the current WB entry; ignore MEM inputs.
- `flush_i` in 1: kill the current WB entry; the next edge loads a bubble.
- `mem_valid_i` in 1: the MEM stage holds a real instruction.
- `mem_regwrite_i` in 1: the instruction writes a GPR.
- `mem_memtoreg_i` in 1: the result comes from data RAM (load), not the ALU.
- `mem_waddr_i` in 5: destination register.
- `mem_alu_result_i` in 32: ALU/link result.
- `mem_load_type_i` in 3: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes are treated as LW.
- `mem_addr_lo_i` in 2: load address bits [1:0].
- `dram_rdata_i` in 32: data-RAM read word. It is valid only in the first cycle an entry sits in WB.
- `rf_we_o` out 1: register file write enable.
- `rf_waddr_o` out 5: register file write address.
- `rf_wdata_o` out 32: register file write data.
- `wb_valid_o` out 1: the WB entry is valid (for the hazard unit).
- `wb_regwrite_o` out 1: the WB entry writes a GPR (for the hazard unit).
- `wb_waddr_o` out 5: WB destination (for the hazard unit).
- `retired_o` out 32: count of retired valid instructions.

## Operation
- **Pipeline register.** Stored fields: valid, regwrite, memtoreg, waddr, alu_result, load_type, addr_lo.
- **Update priority per edge:** `rst_i` > `flush_i` > `stall_i` > load from MEM.
  - Reset and flush both clear valid. On flush, the other fields are don't-care.
  - Stall keeps all fields unchanged.
  - Otherwise all fields load from the `mem_*` inputs.
- **Fresh flag.** Set on every edge that loads a MEM entry. Cleared on reset, on flush, and on any stalled edge.
- **Data hold register.**
  - On an edge where stall is taken while fresh=1, capture `dram_rdata_i` into hold.
  - Raw load word = `dram_rdata_i` when fresh=1, else hold. This keeps the data correct through stalls of any length.
- **Alignment.** Little-endian byte lanes.
  - LB/LBU: select byte [8*addr_lo+7 : 8*addr_lo]; LB sign-extends, LBU zero-extends.
  - LH/LHU: addr_lo[1]=0 selects [15:0], 1 selects [31:16]; addr_lo[0] is ignored because misalignment is trapped upstream. LH sign-extends, LHU zero-extends.
  - LW: the full word.
- **Write data.** `rf_wdata_o` = aligned load data when memtoreg=1, else alu_result.
- **Write enable.** `rf_we_o` = valid & regwrite & (waddr != 0) & ~flush_i.
  - It stays asserted every stalled cycle. Repeated writes of identical data are harmless.
- **Address outputs.** `rf_waddr_o` = `wb_waddr_o` = stored waddr.
- **Hazard outputs.** `wb_valid_o` = valid, `wb_regwrite_o` = regwrite.
- **Retire counter.**
  - Increments by 1 on each edge where valid=1, stall_i=0, and flush_i=0, i.e. once per entry on the edge it leaves WB.
  - Wraps from 0xFFFFFFFF to 0. Cleared only by reset; flush does not clear it.

## Timing
- A MEM entry loaded at edge N is in WB during cycle N..N+1. The register file latches `rf_wdata_o` at edge N+1, when `rf_we_o`=1.
- Same-cycle read-after-write is handled by the register file bypass; `wb_stage` adds no further latency.
- Data RAM returns read data one cycle after MEM presents the address, which is the first WB cycle.
- Reset values (from the edge with `rst_i`=1 onward):
  - valid=0, fresh=0, hold=0, retired_o=0.
  - All outputs 0, including `rf_we_o`=0 and `rf_wdata_o`=0.
  - All stored fields are zeroed.
- Simultaneous stall and flush: flush wins, and the entry is dropped without being counted.
- Reset during a stall: the entry is dropped, and the counter and hold register clear.

## Test plan
- **LW:** entry with waddr=5, memtoreg=1, LW, `dram_rdata_i`=0xDEADBEEF. Required: `rf_we_o`=1, waddr=5, wdata=0xDEADBEEF for one cycle; retired_o goes 0→1.
- **Byte/halfword sweep:** dram word 0x80FF7F01.
  - LB addr 0 → 0x00000001, LB addr 1 → 0x0000007F, LB addr 2 → 0xFFFFFFFF, LBU addr 3 → 0x00000080.
  - LH addr 2 → 0xFFFF80FF, LHU addr 0 → 0x00007F01.
- **Stall across RAM change:** LW with dram=0x12345678, stall for 3 cycles while dram changes to 0xAAAAAAAA. Required: wdata stays 0x12345678 and `rf_we_o`=1 every cycle; retired_o increments exactly once, after the stall releases.
- **Flush and $zero:**
  - Flush during an entry with waddr=7: `rf_we_o` goes 0 that cycle, valid=0 next cycle, no count.
  - ALU entry with waddr=0, result 0x55: `rf_we_o`=0, but retired_o still increments.
- **Reset mid-stream:** back-to-back valid entries, `rst_i` pulsed for one cycle while stalled. Required: all outputs 0 after the edge, retired_o=0, and the next MEM entry writes normally.
- **Counter wrap:** preload by issuing entries until retired_o reaches 0xFFFFFFFF (or force it in the bench). One more retire → 0x00000000.
